// File: rtl/mstq_pkg.sv
// rtl/mstq_pkg.sv - shared constants and state encodings for the master-queue arbiter
package mstq_pkg;

  localparam int MSTQ_W        = 18;
  localparam int TLP_START_BIT = 17;
  localparam int TLP_END_BIT   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } mstq_state_e;

endpackage

// File: rtl/mstq_arbiter.sv
// rtl/mstq_arbiter.sv - packet-atomic round-robin arbiter sharing the master command FIFO
module mstq_arbiter
  import mstq_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int HOLD_MAX = 1024
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              enable,
  input  logic              req0,
  input  logic [MSTQ_W-1:0] din0,
  input  logic              wr_en0,
  output logic              full0,
  input  logic              req1,
  input  logic [MSTQ_W-1:0] din1,
  input  logic              wr_en1,
  output logic              full1,
  output logic [MSTQ_W-1:0] mst_din,
  output logic              mst_wr_en,
  input  logic              mst_full,
  output logic [1:0]        grant,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1,
  output logic              proto_err,
  output logic              hold_timeout,
  input  logic              clr_flags
);

  localparam int IDLE_W = $clog2(HOLD_MAX + 1);

  mstq_state_e       state, state_nxt;
  logic              last_owner;
  logic              first_word;
  logic [IDLE_W-1:0] idle_cnt;
  logic [MSTQ_W-1:0] own_din;
  logic              own_wr;
  logic              accept;
  logic              stray_wr;
  logic              owning;
  logic              err_set;
  logic              hold_set;

  assign owning = (state != ST_IDLE);
  assign grant  = {state == ST_OWN1, state == ST_OWN0};

  always_comb begin
    state_nxt = state;
    own_din   = '0;
    own_wr    = 1'b0;
    stray_wr  = 1'b0;
    full0     = 1'b1;
    full1     = 1'b1;
    case (state)
      ST_IDLE: begin
        stray_wr = wr_en0 | wr_en1;
        if (enable) begin
          if (req0 && req1)
            state_nxt = last_owner ? ST_OWN0 : ST_OWN1;
          else if (req0)
            state_nxt = ST_OWN0;
          else if (req1)
            state_nxt = ST_OWN1;
        end
      end
      ST_OWN0: begin
        full0    = mst_full;
        own_din  = din0;
        own_wr   = wr_en0;
        stray_wr = wr_en1;
      end
      ST_OWN1: begin
        full1    = mst_full;
        own_din  = din1;
        own_wr   = wr_en1;
        stray_wr = wr_en0;
      end
      default: state_nxt = ST_IDLE;
    endcase

    accept = own_wr & ~mst_full;
    // Reset must hold both receivers off and keep the master queue quiet
    if (!sys_rst_n) begin
      full0  = 1'b1;
      full1  = 1'b1;
      accept = 1'b0;
    end
    if (accept && own_din[TLP_END_BIT])
      state_nxt = ST_IDLE;

    mst_din   = own_din;
    mst_wr_en = accept;

    err_set  = stray_wr
             | (accept &  first_word & ~own_din[TLP_START_BIT])
             | (accept & ~first_word &  own_din[TLP_START_BIT]);
    // Flag fires once on reaching the limit so clr_flags can clear it while still stalled
    hold_set = owning & ~accept & (idle_cnt == IDLE_W'(HOLD_MAX - 1));
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state        <= ST_IDLE;
      last_owner   <= 1'b1;
      first_word   <= 1'b1;
      idle_cnt     <= '0;
      pkt_cnt0     <= '0;
      pkt_cnt1     <= '0;
      proto_err    <= 1'b0;
      hold_timeout <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state_nxt == ST_IDLE)
        first_word <= 1'b1;
      else if (accept)
        first_word <= 1'b0;

      if (!owning || accept)
        idle_cnt <= '0;
      else if (idle_cnt != IDLE_W'(HOLD_MAX))
        idle_cnt <= idle_cnt + IDLE_W'(1);

      if (accept && own_din[TLP_END_BIT]) begin
        last_owner <= (state == ST_OWN1);
        if (state == ST_OWN1)
          pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
        else
          pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
      end

      if (err_set)
        proto_err <= 1'b1;
      else if (clr_flags)
        proto_err <= 1'b0;

      if (hold_set)
        hold_timeout <= 1'b1;
      else if (clr_flags)
        hold_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mstq_arbiter.sv
// tb/tb_mstq_arbiter.sv - directed self-checking bench for mstq_arbiter
module tb_mstq_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        enable;
  logic        req0, req1;
  logic [17:0] din0, din1;
  logic        wr_en0, wr_en1;
  logic        full0, full1;
  logic [17:0] mst_din;
  logic        mst_wr_en;
  logic        mst_full;
  logic [1:0]  grant;
  logic [15:0] pkt_cnt0, pkt_cnt1;
  logic        proto_err, hold_timeout;
  logic        clr_flags;

  int tests = 0;
  int fails = 0;

  always #5 sys_clk = ~sys_clk;

  mstq_arbiter #(.CNT_W(16), .HOLD_MAX(1024)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .enable       (enable),
    .req0         (req0),
    .din0         (din0),
    .wr_en0       (wr_en0),
    .full0        (full0),
    .req1         (req1),
    .din1         (din1),
    .wr_en1       (wr_en1),
    .full1        (full1),
    .mst_din      (mst_din),
    .mst_wr_en    (mst_wr_en),
    .mst_full     (mst_full),
    .grant        (grant),
    .pkt_cnt0     (pkt_cnt0),
    .pkt_cnt1     (pkt_cnt1),
    .proto_err    (proto_err),
    .hold_timeout (hold_timeout),
    .clr_flags    (clr_flags)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;
  endtask

  initial begin
    enable = 1'b1; req0 = 0; req1 = 0; din0 = '0; din1 = '0;
    wr_en0 = 0; wr_en1 = 0; mst_full = 0; clr_flags = 0;

    // Reset state
    sys_rst_n = 1'b0;
    tick(); tick();
    #1;
    chk("rst_full0", full0, 1);
    chk("rst_full1", full1, 1);
    chk("rst_wr_en", mst_wr_en, 0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_cnt0", pkt_cnt0, 0);
    chk("rst_flags", {proto_err, hold_timeout}, 2'b00);
    sys_rst_n = 1'b1;

    // Single 3-word TLP from port 0
    req0 = 1;
    tick();
    req0 = 0;
    #1;
    chk("t1_grant", grant, 2'b01);
    din0 = 18'h2_1234; wr_en0 = 1; #1;
    chk("t1_w0_en", mst_wr_en, 1);
    chk("t1_w0_din", mst_din, 18'h2_1234);
    chk("t1_full0", full0, 0);
    chk("t1_full1", full1, 1);
    tick();
    din0 = 18'h0_5678; #1;
    chk("t1_w1_din", mst_din, 18'h0_5678);
    chk("t1_w1_en", mst_wr_en, 1);
    tick();
    din0 = 18'h1_9ABC; #1;
    chk("t1_w2_din", mst_din, 18'h1_9ABC);
    chk("t1_w2_full1", full1, 1);
    tick();
    wr_en0 = 0; #1;
    chk("t1_idle_grant", grant, 2'b00);
    chk("t1_cnt0", pkt_cnt0, 1);
    chk("t1_idle_wr_en", mst_wr_en, 0);
    chk("t1_perr", proto_err, 0);

    // Both ports requesting: strict alternation with one idle cycle between packets
    do_reset();
    req0 = 1; req1 = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      chk("t2_grant", grant, (k % 2 == 0) ? 2'b01 : 2'b10);
      din0 = 18'h2_0000 | 18'(k * 16); din1 = din0;
      wr_en0 = (k % 2 == 0); wr_en1 = (k % 2 == 1); #1;
      chk("t2_start", {mst_wr_en, mst_din}, {1'b1, 18'h2_0000 | 18'(k * 16)});
      tick();
      din0 = 18'h1_0001 | 18'(k * 16); din1 = din0; #1;
      chk("t2_end", {mst_wr_en, mst_din}, {1'b1, 18'h1_0001 | 18'(k * 16)});
      tick();
      wr_en0 = 0; wr_en1 = 0; #1;
      chk("t2_idle", grant, 2'b00);
    end
    req0 = 0; req1 = 0;
    chk("t2_cnts", {pkt_cnt0, pkt_cnt1}, {16'd2, 16'd2});
    chk("t2_perr", proto_err, 0);

    // Master FIFO stall mid-packet, including on the end word
    tick();
    req0 = 1;
    tick();
    req0 = 0;
    din0 = 18'h2_AAAA; wr_en0 = 1; #1;
    chk("t3_start", {grant, mst_wr_en}, {2'b01, 1'b1});
    tick();
    din0 = 18'h0_BBBB; mst_full = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_stall", {grant, mst_wr_en, full0}, {2'b01, 1'b0, 1'b1});
      tick();
    end
    mst_full = 0; #1;
    chk("t3_resume", {mst_wr_en, mst_din, full0}, {1'b1, 18'h0_BBBB, 1'b0});
    tick();
    din0 = 18'h1_CCCC; mst_full = 1; #1;
    chk("t3_end_blocked", mst_wr_en, 0);
    tick();
    #1;
    chk("t3_end_hold", grant, 2'b01);
    mst_full = 0; #1;
    chk("t3_end_acc", {mst_wr_en, mst_din}, {1'b1, 18'h1_CCCC});
    tick();
    wr_en0 = 0; #1;
    chk("t3_done", {grant, pkt_cnt0, hold_timeout}, {2'b00, 16'd3, 1'b0});

    // Owner 1 stalls for HOLD_MAX cycles
    req1 = 1;
    tick();
    req1 = 0;
    din1 = 18'h2_1111; wr_en1 = 1; #1;
    chk("t4_grant", grant, 2'b10);
    tick();
    wr_en1 = 0;
    repeat (1023) @(posedge sys_clk);
    #1;
    chk("t4_before_limit", hold_timeout, 0);
    tick();
    chk("t4_timeout", {hold_timeout, grant}, {1'b1, 2'b10});
    clr_flags = 1;
    tick();
    clr_flags = 0; #1;
    chk("t4_cleared", {hold_timeout, grant}, {1'b0, 2'b10});
    din1 = 18'h1_2222; wr_en1 = 1; #1;
    chk("t4_end", {mst_wr_en, mst_din}, {1'b1, 18'h1_2222});
    tick();
    wr_en1 = 0; #1;
    chk("t4_done", {grant, pkt_cnt1, proto_err}, {2'b00, 16'd3, 1'b0});

    // enable gating: no new grant, in-flight packet completes
    enable = 0; req1 = 1;
    tick();
    chk("t5_disabled", grant, 2'b00);
    enable = 1;
    tick();
    enable = 0;
    din1 = 18'h3_7777; wr_en1 = 1; #1;
    chk("t5_onword", {grant, mst_wr_en, mst_din}, {2'b10, 1'b1, 18'h3_7777});
    tick();
    wr_en1 = 0;
    tick();
    chk("t5_stay_idle", {grant, pkt_cnt1}, {2'b00, 16'd4});
    req1 = 0; enable = 1;

    // Non-owner write is dropped and flagged
    req0 = 1;
    tick();
    req0 = 0;
    din0 = 18'h2_3333; wr_en0 = 1;
    tick();
    wr_en0 = 0; din0 = 18'h0_0000; din1 = 18'h0_DEAD; wr_en1 = 1; #1;
    chk("t6_drop", {grant, mst_wr_en, full1, proto_err}, {2'b01, 1'b0, 1'b1, 1'b0});
    tick();
    wr_en1 = 0; #1;
    chk("t6_perr", proto_err, 1);
    din0 = 18'h1_4444; wr_en0 = 1;
    tick();
    wr_en0 = 0; #1;
    chk("t6_cnt0", {grant, pkt_cnt0}, {2'b00, 16'd4});
    clr_flags = 1; wr_en0 = 1;
    tick();
    wr_en0 = 0; #1;
    chk("t6_err_wins", proto_err, 1);
    tick();
    clr_flags = 0; #1;
    chk("t6_cleared", proto_err, 0);

    // Reset mid-packet, then a normal one-word packet
    req0 = 1;
    tick();
    req0 = 0;
    din0 = 18'h2_9999; wr_en0 = 1;
    tick();
    sys_rst_n = 0; #1;
    chk("t7_in_reset", {full0, full1, mst_wr_en}, {1'b1, 1'b1, 1'b0});
    tick();
    sys_rst_n = 1; wr_en0 = 0; #1;
    chk("t7_post_rst", {grant, pkt_cnt0, pkt_cnt1, proto_err, hold_timeout},
        {2'b00, 16'd0, 16'd0, 2'b00});
    req0 = 1;
    tick();
    req0 = 0;
    din0 = 18'h3_5555; wr_en0 = 1; #1;
    chk("t7_grant", {grant, mst_wr_en, mst_din}, {2'b01, 1'b1, 18'h3_5555});
    tick();
    wr_en0 = 0; #1;
    chk("t7_done", {grant, pkt_cnt0, proto_err}, {2'b00, 16'd1, 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
